// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types, phase table and width helpers for the step scheduler
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2
    } state_e;

    // Full-step forward order; element [0] is index 0 (1100).
    localparam logic [3:0][3:0] PHASE_TABLE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};

    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/button_edge.sv
// rtl/button_edge.sv - single-bit registered rising-edge detector
module button_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/motor_step_scheduler.sv
// rtl/motor_step_scheduler.sv - button-driven speed/direction control and full-step phase sequencer
module motor_step_scheduler
    import motor_pkg::*;
#(
    parameter int unsigned DIV_BASE     = 12500,
    parameter int unsigned NUM_LEVELS   = 8,
    parameter int unsigned BRAKE_CYCLES = 25000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_dir,
    input  logic                          btn_stop,
    output logic [3:0]                    phase_out,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic                          dir,
    output logic                          running,
    output logic                          step_pulse
);

    localparam int unsigned LW = $clog2(NUM_LEVELS);
    localparam int unsigned CW = width_of(DIV_BASE * NUM_LEVELS);
    localparam int unsigned BW = width_of(BRAKE_CYCLES);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(NUM_LEVELS - 1);
    localparam logic [BW-1:0] BRK_LAST  = BW'(BRAKE_CYCLES - 1);

    logic up_e, down_e, dir_e, stop_e;

    button_edge u_up   (.clk(clk), .rst_n(rst_n), .btn_i(btn_up),   .rise_o(up_e));
    button_edge u_down (.clk(clk), .rst_n(rst_n), .btn_i(btn_down), .rise_o(down_e));
    button_edge u_dir  (.clk(clk), .rst_n(rst_n), .btn_i(btn_dir),  .rise_o(dir_e));
    button_edge u_stop (.clk(clk), .rst_n(rst_n), .btn_i(btn_stop), .rise_o(stop_e));

    state_e        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic          dir_q, dir_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] brk_q, brk_d;
    logic          step_q, step_d;
    logic [31:0]   period_m1;
    logic          at_period;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            dir_q   <= 1'b0;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            brk_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            brk_q   <= brk_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        level_d = level_q;
        if (stop_e) begin
            level_d = '0;
        end else if (up_e && !down_e) begin
            if (level_q != LEVEL_MAX) level_d = level_q + LW'(1);
        end else if (down_e && !up_e) begin
            if (level_q != '0) level_d = level_q - LW'(1);
        end
    end

    // Compare uses the registered level, so a level change shifts the period from the next edge on.
    assign period_m1 = DIV_BASE * (NUM_LEVELS - 32'(level_q)) - 32'd1;
    assign at_period = (32'(cnt_q) >= period_m1);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q ^ dir_e;
        idx_d   = idx_q;
        cnt_d   = '0;
        brk_d   = '0;
        step_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_d != '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (level_d == '0) begin
                    state_d = ST_IDLE;
                end else if (dir_e) begin
                    state_d = ST_BRAKE;
                end else if (at_period) begin
                    idx_d  = dir_q ? (idx_q - 2'd1) : (idx_q + 2'd1);
                    step_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BRAKE: begin
                if (level_d == '0) begin
                    state_d = ST_IDLE;
                end else if (dir_e) begin
                    brk_d = '0;
                end else if (brk_q == BRK_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    brk_d = brk_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign running    = (state_q == ST_RUN);
    assign phase_out  = running ? PHASE_TABLE[idx_q] : 4'b0000;
    assign level      = level_q;
    assign dir        = dir_q;
    assign step_pulse = step_q;

endmodule

// File: tb/tb_motor_step_scheduler.sv
// tb/tb_motor_step_scheduler.sv - directed self-checking bench for motor_step_scheduler
module tb_motor_step_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_dir = 1'b0, btn_stop = 1'b0;
    logic [3:0] phase_out;
    logic [1:0] level;
    logic       dir, running, step_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    motor_step_scheduler #(
        .DIV_BASE(4), .NUM_LEVELS(4), .BRAKE_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_dir(btn_dir), .btn_stop(btn_stop),
        .phase_out(phase_out), .level(level), .dir(dir),
        .running(running), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!step_pulse && n < 100);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"}, 32'(phase_out), 32'h0);
        chk({tag, "_level"}, 32'(level), 32'h0);
        chk({tag, "_dir"}, 32'(dir), 32'h0);
        chk({tag, "_run"}, 32'(running), 32'h0);
        chk({tag, "_step"}, 32'(step_pulse), 32'h0);
    endtask

    int n;
    int k;
    logic [3:0] fwd_seq [4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};

    initial begin
        #12;
        chk_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Start: one up edge, level 1, period 12.
        btn_up = 1'b1; tick(); btn_up = 1'b0;
        chk("start_level", 32'(level), 32'd1);
        chk("start_run", 32'(running), 32'd1);
        chk("start_phase", 32'(phase_out), 32'hC);
        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            chk("fwd_period", 32'(n), 32'd12);
            chk("fwd_phase", 32'(phase_out), 32'(fwd_seq[i]));
        end

        // Saturation at level 3, period 4.
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
        end
        chk("sat_level", 32'(level), 32'd3);
        wait_step(n);
        wait_step(n);
        chk("sat_period", 32'(n), 32'd4);
        btn_up = 1'b1; btn_down = 1'b1; tick(); btn_up = 1'b0; btn_down = 1'b0; tick();
        chk("updown_level", 32'(level), 32'd3);

        // Reversal with brake from index 2.
        k = 0;
        do begin
            wait_step(n);
            k++;
        end while (phase_out != 4'b0011 && k < 8);
        chk("find_idx2", 32'(phase_out), 32'h3);
        btn_dir = 1'b1; tick(); btn_dir = 1'b0;
        chk("brake_phase", 32'(phase_out), 32'h0);
        chk("brake_dir", 32'(dir), 32'd1);
        n = 1;
        do begin
            tick();
            if (!running) n++;
        end while (!running && n < 50);
        chk("brake_len", 32'(n), 32'd3);
        chk("resume_phase", 32'(phase_out), 32'h3);
        wait_step(n);
        chk("rev_period", 32'(n), 32'd4);
        chk("rev_phase1", 32'(phase_out), 32'h6);
        wait_step(n);
        chk("rev_phase0", 32'(phase_out), 32'hC);
        wait_step(n);
        chk("rev_wrap3", 32'(phase_out), 32'h9);

        // Stop, then direction change in IDLE.
        btn_stop = 1'b1; tick(); btn_stop = 1'b0;
        chk("stop_level", 32'(level), 32'd0);
        chk("stop_run", 32'(running), 32'd0);
        chk("stop_phase", 32'(phase_out), 32'h0);
        btn_dir = 1'b1; tick(); btn_dir = 1'b0;
        chk("idle_dir", 32'(dir), 32'd0);
        chk("idle_run", 32'(running), 32'd0);
        tick();
        btn_up = 1'b1; tick(); btn_up = 1'b0;
        chk("idle_restart_run", 32'(running), 32'd1);
        chk("idle_restart_phase", 32'(phase_out), 32'h9);

        // Second dir edge two samples after the first restarts the brake.
        btn_dir = 1'b1; tick(); btn_dir = 1'b0;
        chk("rt_brake1", 32'(running), 32'd0);
        tick();
        btn_dir = 1'b1; tick(); btn_dir = 1'b0;
        chk("rt_dir", 32'(dir), 32'd0);
        chk("rt_brake2", 32'(running), 32'd0);
        n = 1;
        do begin
            tick();
            if (!running) n++;
        end while (!running && n < 50);
        chk("rt_brake_after_restart", 32'(n), 32'd3);
        chk("rt_resume_phase", 32'(phase_out), 32'h9);

        // Asynchronous reset mid-run with btn_up held.
        btn_up = 1'b1; tick();
        chk("pre_rst_level", 32'(level), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_rst_level", 32'(level), 32'd1);
        chk("post_rst_phase", 32'(phase_out), 32'hC);
        repeat (3) tick();
        chk("held_one_edge", 32'(level), 32'd1);
        btn_up = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
